// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU memory unit: bus widths, address
// map region bounds and the program-loader state encoding.
package cpu_mem_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned ADDR_W     = 8;

   localparam logic [7:0]  PROG_BASE  = 8'h00;
   localparam logic [7:0]  PROG_LIMIT = 8'h7F;
   localparam logic [7:0]  RAM_BASE   = 8'h80;
   localparam logic [7:0]  RAM_LIMIT  = 8'hDF;
   localparam logic [7:0]  OUT_BASE   = 8'hE0;
   localparam logic [7:0]  OUT_LIMIT  = 8'hEF;
   localparam logic [7:0]  IN_BASE    = 8'hF0;

   localparam int unsigned PROG_DEPTH = 128;
   localparam int unsigned RAM_DEPTH  = 96;
   localparam int unsigned NUM_PORTS  = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOADING,
      S_DONE
   } load_state_t;

endpackage

// File: rtl/memory_unit_input_synchronizer.sv
// STAGES-deep flop chain bringing an asynchronous input vector into the clk
// domain; STAGES is expected to be 2 or 3.
module input_synchronizer #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES*WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
      end
   end

   assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/memory_unit.sv
// Memory-side responder for the 8-bit CPU: program store, data RAM, 16 output
// and 16 synchronised input ports, plus a program loader. MEMORY_UNIT_FAULT_EN adds fault/fault_addr.
module memory_unit
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = cpu_mem_pkg::DATA_W,
   parameter int unsigned ADDR_W      = cpu_mem_pkg::ADDR_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [ADDR_W-1:0]              address,
   input  logic [DATA_W-1:0]              to_memory,
   input  logic                           write,
   output logic [DATA_W-1:0]              from_memory,
   input  logic [NUM_PORTS*DATA_W-1:0]    port_in,
   output logic [NUM_PORTS*DATA_W-1:0]    port_out,
   input  logic                           prog_load_en,
   input  logic [6:0]                     prog_addr,
   input  logic [DATA_W-1:0]              prog_data,
   output logic                           cpu_hold,
   output logic                           prog_done
`ifdef MEMORY_UNIT_FAULT_EN
   ,
   output logic                           fault,
   output logic [ADDR_W-1:0]              fault_addr
`endif
);

   logic [DATA_W-1:0] prog_mem [PROG_DEPTH];
   logic [DATA_W-1:0] ram      [RAM_DEPTH];
   logic [DATA_W-1:0] out_reg  [NUM_PORTS];
   logic [DATA_W-1:0] in_sync  [NUM_PORTS];

   logic        is_prog, is_ram, is_out, is_in;
   logic [6:0]  prog_idx, ram_idx;
   logic [3:0]  out_idx, in_idx;
   logic [DATA_W-1:0] rd_data;

   load_state_t state_q, state_d;

   // Address decode
   assign is_prog  = (address <= PROG_LIMIT);
   assign is_ram   = (address >= RAM_BASE) && (address <= RAM_LIMIT);
   assign is_out   = (address >= OUT_BASE) && (address <= OUT_LIMIT);
   assign is_in    = (address >= IN_BASE);
   assign prog_idx = 7'(address - PROG_BASE);
   assign ram_idx  = 7'(address - RAM_BASE);
   assign out_idx  = 4'(address - OUT_BASE);
   assign in_idx   = 4'(address - IN_BASE);

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_sync
         input_synchronizer #(
            .WIDTH  (DATA_W),
            .STAGES (SYNC_STAGES)
         ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (port_in[g*DATA_W +: DATA_W]),
            .q     (in_sync[g])
         );
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (is_prog)     rd_data = prog_mem[prog_idx];
      else if (is_ram) rd_data = ram[ram_idx];
      else if (is_out) rd_data = out_reg[out_idx];
      else if (is_in)  rd_data = in_sync[in_idx];
   end

   // Registered read of the pre-edge array contents gives read-before-write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         from_memory <= '0;
      end else begin
         from_memory <= rd_data;
      end
   end

   // Storage arrays are deliberately left out of reset
   always_ff @(posedge clk) begin
      if (prog_load_en) prog_mem[prog_addr] <= prog_data;
      if (write && is_ram) ram[ram_idx] <= to_memory;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) out_reg[i] <= '0;
      end else if (write && is_out) begin
         out_reg[out_idx] <= to_memory;
      end
   end

   always_comb begin
      port_out = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         port_out[k*DATA_W +: DATA_W] = out_reg[k];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      prog_done = 1'b0;
      cpu_hold  = prog_load_en;
      unique case (state_q)
         S_IDLE: begin
            if (prog_load_en) state_d = S_LOADING;
         end
         S_LOADING: begin
            cpu_hold = 1'b1;
            if (!prog_load_en) state_d = S_DONE;
         end
         S_DONE: begin
            cpu_hold  = 1'b1;
            prog_done = 1'b1;
            state_d   = prog_load_en ? S_LOADING : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef MEMORY_UNIT_FAULT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (write && (is_prog || is_in) && !fault) begin
         fault      <= 1'b1;
         fault_addr <= address;
      end
   end
`else
   // Writes to program or input-port space are simply dropped by the decode
`endif

endmodule
